// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops, snoops the ALU and load/store CDBs for operand
// wakeup and issues the lowest-index ready entry. Build option: RS_WAKEUP_ISSUE_EN.
module reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int ROB_ID_W = 5,
  parameter int OPENUM_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ena_from_dsp,
  input  logic [OPENUM_W-1:0] openum_from_dsp,
  input  logic [31:0]         V1_from_dsp,
  input  logic [31:0]         V2_from_dsp,
  input  logic [ROB_ID_W-1:0] Q1_from_dsp,
  input  logic [ROB_ID_W-1:0] Q2_from_dsp,
  input  logic [31:0]         pc_from_dsp,
  input  logic [31:0]         imm_from_dsp,
  input  logic [ROB_ID_W-1:0] rob_id_from_dsp,
  input  logic                valid_from_rs_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb,
  input  logic [31:0]         result_from_rs_cdb,
  input  logic                valid_from_ls_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
  input  logic [31:0]         result_from_ls_cdb,
  input  logic                rollback_flag_from_rob,
  output logic                full_to_if,
  output logic                ena_to_alu,
  output logic [OPENUM_W-1:0] openum_to_alu,
  output logic [31:0]         V1_to_alu,
  output logic [31:0]         V2_to_alu,
  output logic [31:0]         pc_to_alu,
  output logic [31:0]         imm_to_alu,
  output logic [ROB_ID_W-1:0] rob_id_to_alu
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] q;
    logic [31:0]         v;
  } opnd_t;

  // Tag 0 is a resolved operand and never matches; the ALU bus wins over the load/store bus.
  function automatic opnd_t snoop(
    input logic [ROB_ID_W-1:0] q,
    input logic [31:0]         v,
    input logic                rs_vld,
    input logic [ROB_ID_W-1:0] rs_tag,
    input logic [31:0]         rs_val,
    input logic                ls_vld,
    input logic [ROB_ID_W-1:0] ls_tag,
    input logic [31:0]         ls_val
  );
    opnd_t r;
    r.q = q;
    r.v = v;
    if (q != '0) begin
      if (rs_vld && (q == rs_tag)) begin
        r.q = '0;
        r.v = rs_val;
      end else if (ls_vld && (q == ls_tag)) begin
        r.q = '0;
        r.v = ls_val;
      end
    end
    return r;
  endfunction

  logic [RS_SIZE-1:0]  busy_reg;
  logic [RS_SIZE-1:0]  busy_next;
  logic [OPENUM_W-1:0] openum_reg [RS_SIZE];
  logic [31:0]         v1_reg     [RS_SIZE];
  logic [31:0]         v2_reg     [RS_SIZE];
  logic [ROB_ID_W-1:0] q1_reg     [RS_SIZE];
  logic [ROB_ID_W-1:0] q2_reg     [RS_SIZE];
  logic [31:0]         pc_reg     [RS_SIZE];
  logic [31:0]         imm_reg    [RS_SIZE];
  logic [ROB_ID_W-1:0] rob_id_reg [RS_SIZE];

  opnd_t               op1_next [RS_SIZE];
  opnd_t               op2_next [RS_SIZE];
  logic [RS_SIZE-1:0]  ready;
  opnd_t               ins_op1;
  opnd_t               ins_op2;
  logic                ins_hit;
  logic [IDX_W-1:0]    ins_idx;
  logic                issue_hit;
  logic [IDX_W-1:0]    issue_idx;
  logic                do_insert;
  logic                do_issue;
  logic [CNT_W-1:0]    busy_cnt_next;
  logic                full_next;

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign op1_next[gi] = snoop(q1_reg[gi], v1_reg[gi],
                                  valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
                                  valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb);
      assign op2_next[gi] = snoop(q2_reg[gi], v2_reg[gi],
                                  valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
                                  valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb);
`ifdef RS_WAKEUP_ISSUE_EN
      assign ready[gi] = busy_reg[gi] && (op1_next[gi].q == '0) && (op2_next[gi].q == '0);
`else
      assign ready[gi] = busy_reg[gi] && (q1_reg[gi] == '0) && (q2_reg[gi] == '0);
`endif
    end
  endgenerate

  assign ins_op1 = snoop(Q1_from_dsp, V1_from_dsp,
                         valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
                         valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb);
  assign ins_op2 = snoop(Q2_from_dsp, V2_from_dsp,
                         valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb,
                         valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb);

  // Insert slot is chosen from the registered busy bits, so a slot freed by this cycle's issue stays empty.
  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    ins_hit   = 1'b0;
    ins_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_hit = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!busy_reg[i]) begin
        ins_hit = 1'b1;
        ins_idx = IDX_W'(i);
      end
    end
  end

  assign do_issue  = issue_hit && !rollback_flag_from_rob;
  assign do_insert = ena_from_dsp && ins_hit && !rollback_flag_from_rob;

  always_comb begin
    busy_next = busy_reg;
    if (do_issue) begin
      busy_next[issue_idx] = 1'b0;
    end
    if (do_insert) begin
      busy_next[ins_idx] = 1'b1;
    end
    if (rollback_flag_from_rob) begin
      busy_next = '0;
    end
    busy_cnt_next = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_cnt_next = busy_cnt_next + CNT_W'(busy_next[i]);
    end
    // One slot of headroom covers the dispatch already in flight when fetch sees full.
    full_next = (busy_cnt_next >= CNT_W'(RS_SIZE - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg      <= '0;
      full_to_if    <= 1'b0;
      ena_to_alu    <= 1'b0;
      openum_to_alu <= '0;
      V1_to_alu     <= '0;
      V2_to_alu     <= '0;
      pc_to_alu     <= '0;
      imm_to_alu    <= '0;
      rob_id_to_alu <= '0;
    end else if (rdy) begin
      busy_reg   <= busy_next;
      full_to_if <= full_next;
      ena_to_alu <= do_issue;
      if (do_issue) begin
        openum_to_alu <= openum_reg[issue_idx];
        V1_to_alu     <= op1_next[issue_idx].v;
        V2_to_alu     <= op2_next[issue_idx].v;
        pc_to_alu     <= pc_reg[issue_idx];
        imm_to_alu    <= imm_reg[issue_idx];
        rob_id_to_alu <= rob_id_reg[issue_idx];
      end
    end
  end

  // Payload needs no reset: an entry's fields are only observed while its busy bit is set.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (do_insert && (ins_idx == IDX_W'(i))) begin
          openum_reg[i] <= openum_from_dsp;
          q1_reg[i]     <= ins_op1.q;
          v1_reg[i]     <= ins_op1.v;
          q2_reg[i]     <= ins_op2.q;
          v2_reg[i]     <= ins_op2.v;
          pc_reg[i]     <= pc_from_dsp;
          imm_reg[i]    <= imm_from_dsp;
          rob_id_reg[i] <= rob_id_from_dsp;
        end else if (busy_reg[i]) begin
          q1_reg[i] <= op1_next[i].q;
          v1_reg[i] <= op1_next[i].v;
          q2_reg[i] <= op2_next[i].q;
          v2_reg[i] <= op2_next[i].v;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: stimulus pushes expected issues, a negedge monitor checks them.
module tb_reservation_station;

`ifdef RS_WAKEUP_ISSUE_EN
  localparam int WAKE_LAT = 0;
`else
  localparam int WAKE_LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ena_from_dsp;
  logic [5:0]  openum_from_dsp;
  logic [31:0] V1_from_dsp;
  logic [31:0] V2_from_dsp;
  logic [4:0]  Q1_from_dsp;
  logic [4:0]  Q2_from_dsp;
  logic [31:0] pc_from_dsp;
  logic [31:0] imm_from_dsp;
  logic [4:0]  rob_id_from_dsp;
  logic        valid_from_rs_cdb;
  logic [4:0]  rob_id_from_rs_cdb;
  logic [31:0] result_from_rs_cdb;
  logic        valid_from_ls_cdb;
  logic [4:0]  rob_id_from_ls_cdb;
  logic [31:0] result_from_ls_cdb;
  logic        rollback_flag_from_rob;
  logic        full_to_if;
  logic        ena_to_alu;
  logic [5:0]  openum_to_alu;
  logic [31:0] V1_to_alu;
  logic [31:0] V2_to_alu;
  logic [31:0] pc_to_alu;
  logic [31:0] imm_to_alu;
  logic [4:0]  rob_id_to_alu;

  reservation_station #(.RS_SIZE(16), .ROB_ID_W(5), .OPENUM_W(6)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .ena_from_dsp           (ena_from_dsp),
    .openum_from_dsp        (openum_from_dsp),
    .V1_from_dsp            (V1_from_dsp),
    .V2_from_dsp            (V2_from_dsp),
    .Q1_from_dsp            (Q1_from_dsp),
    .Q2_from_dsp            (Q2_from_dsp),
    .pc_from_dsp            (pc_from_dsp),
    .imm_from_dsp           (imm_from_dsp),
    .rob_id_from_dsp        (rob_id_from_dsp),
    .valid_from_rs_cdb      (valid_from_rs_cdb),
    .rob_id_from_rs_cdb     (rob_id_from_rs_cdb),
    .result_from_rs_cdb     (result_from_rs_cdb),
    .valid_from_ls_cdb      (valid_from_ls_cdb),
    .rob_id_from_ls_cdb     (rob_id_from_ls_cdb),
    .result_from_ls_cdb     (result_from_ls_cdb),
    .rollback_flag_from_rob (rollback_flag_from_rob),
    .full_to_if             (full_to_if),
    .ena_to_alu             (ena_to_alu),
    .openum_to_alu          (openum_to_alu),
    .V1_to_alu              (V1_to_alu),
    .V2_to_alu              (V2_to_alu),
    .pc_to_alu              (pc_to_alu),
    .imm_to_alu             (imm_to_alu),
    .rob_id_to_alu          (rob_id_to_alu)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rob;
    logic [31:0] cyc;
  } iss_t;

  iss_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   occ    = 0;
  int   c;
  int   d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issue pulse must match the oldest expected issue, including the cycle it lands in.
  always @(negedge clk) begin
    iss_t act;
    iss_t e;
    if (rst && ena_to_alu) begin
      act.op  = openum_to_alu;
      act.v1  = V1_to_alu;
      act.v2  = V2_to_alu;
      act.pc  = pc_to_alu;
      act.imm = imm_to_alu;
      act.rob = rob_id_to_alu;
      act.cyc = 32'(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got rob=%0d v1=%h at cycle %0d, required no issue",
                 act.rob, act.v1, cyc);
      end else begin
        e = exp_q.pop_front();
        occ--;
        if (act !== e) begin
          errors++;
          $display("FAIL issue_rob%0d: got op=%h v1=%h v2=%h pc=%h imm=%h rob=%0d cyc=%0d, required op=%h v1=%h v2=%h pc=%h imm=%h rob=%0d cyc=%0d",
                   e.rob, act.op, act.v1, act.v2, act.pc, act.imm, act.rob, act.cyc,
                   e.op, e.v1, e.v2, e.pc, e.imm, e.rob, e.cyc);
        end else begin
          $display("issue rob=%0d op=%h v1=%h v2=%h cycle=%0d ok", act.rob, act.op, act.v1, act.v2, act.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rob,
                              input int at);
    iss_t e;
    e.op  = op;
    e.v1  = v1;
    e.v2  = v2;
    e.pc  = pc;
    e.imm = imm;
    e.rob = rob;
    e.cyc = 32'(at);
    exp_q.push_back(e);
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [4:0] q1, input logic [4:0] q2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [4:0] rob);
    ena_from_dsp    = 1'b1;
    openum_from_dsp = op;
    V1_from_dsp     = v1;
    V2_from_dsp     = v2;
    Q1_from_dsp     = q1;
    Q2_from_dsp     = q2;
    pc_from_dsp     = pc;
    imm_from_dsp    = imm;
    rob_id_from_dsp = rob;
  endtask

  // One dispatch, held for a single clock; inserting into a full station is a protocol violation.
  task automatic dispatch(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [4:0] q1, input logic [4:0] q2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [4:0] rob);
    if (occ >= 16) begin
      errors++;
      $display("FAIL insert_when_full: got occupancy %0d, required below 16", occ);
    end
    occ++;
    drive_op(op, v1, v2, q1, q2, pc, imm, rob);
    tick(1);
    ena_from_dsp = 1'b0;
  endtask

  task automatic rs_cdb(input logic vld, input logic [4:0] tag, input logic [31:0] val);
    valid_from_rs_cdb  = vld;
    rob_id_from_rs_cdb = tag;
    result_from_rs_cdb = val;
  endtask

  task automatic ls_cdb(input logic vld, input logic [4:0] tag, input logic [31:0] val);
    valid_from_ls_cdb  = vld;
    rob_id_from_ls_cdb = tag;
    result_from_ls_cdb = val;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rollback_flag_from_rob = 1'b0;
    drive_op(6'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    ena_from_dsp = 1'b0;
    rs_cdb(1'b0, 5'd0, 32'd0);
    ls_cdb(1'b0, 5'd0, 32'd0);
    #1 rst = 1'b0;

    // Reset state
    tick(3);
    check("reset_ena", {31'd0, ena_to_alu}, 32'd0);
    check("reset_full", {31'd0, full_to_if}, 32'd0);
    check("reset_v1", V1_to_alu, 32'd0);
    check("reset_rob", {27'd0, rob_id_to_alu}, 32'd0);
    check("reset_imm", imm_to_alu, 32'd0);
    rst = 1'b1;
    tick(1);

    // Both operands ready at insert: issue the cycle after insertion
    c = cyc;
    expect_issue(6'd1, 32'd5, 32'd7, 32'h100, 32'd4, 5'd3, c + 2);
    dispatch(6'd1, 32'd5, 32'd7, 5'd0, 5'd0, 32'h100, 32'd4, 5'd3);
    tick(3);

    // Q1 woken by the ALU bus two cycles after insert
    c = cyc;
    expect_issue(6'd2, 32'h10, 32'd9, 32'h104, 32'd8, 5'd7, c + 3 + WAKE_LAT);
    dispatch(6'd2, 32'hDEAD_BEEF, 32'd9, 5'd4, 5'd0, 32'h104, 32'd8, 5'd7);
    tick(1);
    rs_cdb(1'b1, 5'd4, 32'h10);
    tick(1);
    rs_cdb(1'b0, 5'd0, 32'd0);
    tick(3);

    // Q2 captured from the load/store bus during the insert itself
    c = cyc;
    expect_issue(6'd3, 32'd1, 32'hAB, 32'h108, 32'd12, 5'd8, c + 2);
    ls_cdb(1'b1, 5'd6, 32'hAB);
    dispatch(6'd3, 32'd1, 32'h5555, 5'd0, 5'd6, 32'h108, 32'd12, 5'd8);
    ls_cdb(1'b0, 5'd0, 32'd0);
    tick(3);

    // Both buses carry the same tag at insert: the ALU bus value wins
    c = cyc;
    expect_issue(6'd4, 32'h111, 32'd2, 32'h10C, 32'd16, 5'd9, c + 2);
    rs_cdb(1'b1, 5'd9, 32'h111);
    ls_cdb(1'b1, 5'd9, 32'h222);
    dispatch(6'd4, 32'h9999, 32'd2, 5'd9, 5'd0, 32'h10C, 32'd16, 5'd9);
    rs_cdb(1'b0, 5'd0, 32'd0);
    ls_cdb(1'b0, 5'd0, 32'd0);
    tick(3);

    // Both operands of one entry wake in the same cycle from different buses
    c = cyc;
    expect_issue(6'd5, 32'hA0, 32'hB1, 32'h110, 32'd20, 5'd10, c + 2 + WAKE_LAT);
    dispatch(6'd5, 32'd0, 32'd0, 5'd10, 5'd11, 32'h110, 32'd20, 5'd10);
    rs_cdb(1'b1, 5'd10, 32'hA0);
    ls_cdb(1'b1, 5'd11, 32'hB1);
    tick(1);
    rs_cdb(1'b0, 5'd0, 32'd0);
    ls_cdb(1'b0, 5'd0, 32'd0);
    tick(3);

    // Two entries wake together: lowest index (older insert) goes first
    c = cyc;
    expect_issue(6'd6, 32'h20, 32'h61, 32'h114, 32'd0, 5'd12, c + 3 + WAKE_LAT);
    expect_issue(6'd7, 32'h20, 32'h62, 32'h118, 32'd0, 5'd13, c + 4 + WAKE_LAT);
    dispatch(6'd6, 32'd0, 32'h61, 5'd20, 5'd0, 32'h114, 32'd0, 5'd12);
    dispatch(6'd7, 32'd0, 32'h62, 5'd20, 5'd0, 32'h118, 32'd0, 5'd13);
    rs_cdb(1'b1, 5'd20, 32'h20);
    tick(1);
    rs_cdb(1'b0, 5'd0, 32'd0);
    tick(4);

    // rdy low: pending issue is delayed and a concurrent insert is ignored
    c = cyc;
    expect_issue(6'd8, 32'h30, 32'h31, 32'h120, 32'd1, 5'd24, c + 5);
    dispatch(6'd8, 32'h30, 32'h31, 5'd0, 5'd0, 32'h120, 32'd1, 5'd24);
    rdy = 1'b0;
    drive_op(6'd8, 32'h77, 32'h78, 5'd0, 5'd0, 32'h124, 32'd2, 5'd25);
    tick(1);
    check("rdy_low_no_issue", {31'd0, ena_to_alu}, 32'd0);
    tick(2);
    ena_from_dsp = 1'b0;
    rdy = 1'b1;
    tick(4);

    // Fill 15 entries with blocked ops: full rises exactly on the 15th
    for (int i = 0; i < 15; i++) begin
      dispatch(6'd9, 32'd0, 32'(i), (i == 0) ? 5'd30 : 5'd31, 5'd0, 32'h200 + 32'(4 * i), 32'd0, 5'(i + 1));
      check($sformatf("full_after_%0d", i + 1), {31'd0, full_to_if}, (i == 14) ? 32'd1 : 32'd0);
    end
    d = cyc;
    expect_issue(6'd9, 32'h40, 32'd0, 32'h200, 32'd0, 5'd1, d + 1 + WAKE_LAT);
    rs_cdb(1'b1, 5'd30, 32'h40);
    tick(1);
    rs_cdb(1'b0, 5'd0, 32'd0);
    check("full_wake_cycle", {31'd0, full_to_if}, 32'(WAKE_LAT));
    tick(1);
    check("full_after_issue", {31'd0, full_to_if}, 32'd0);
    dispatch(6'd9, 32'd0, 32'h99, 5'd31, 5'd0, 32'h300, 32'd0, 5'd16);
    check("full_refill", {31'd0, full_to_if}, 32'd1);
    rollback_flag_from_rob = 1'b1;
    tick(1);
    rollback_flag_from_rob = 1'b0;
    occ = 0;
    check("full_after_rollback", {31'd0, full_to_if}, 32'd0);
    check("ena_after_rollback", {31'd0, ena_to_alu}, 32'd0);
    rs_cdb(1'b1, 5'd31, 32'h77);
    tick(1);
    rs_cdb(1'b0, 5'd0, 32'd0);
    tick(3);

    // Three entries ready when rollback arrives, plus a same-cycle insert: nothing may issue
    dispatch(6'd10, 32'd0, 32'd1, 5'd22, 5'd0, 32'h400, 32'd0, 5'd26);
    dispatch(6'd10, 32'd0, 32'd2, 5'd22, 5'd0, 32'h404, 32'd0, 5'd27);
    dispatch(6'd10, 32'd0, 32'd3, 5'd22, 5'd0, 32'h408, 32'd0, 5'd28);
    rs_cdb(1'b1, 5'd22, 32'd1);
`ifndef RS_WAKEUP_ISSUE_EN
    tick(1);
    rs_cdb(1'b0, 5'd0, 32'd0);
`endif
    rollback_flag_from_rob = 1'b1;
    drive_op(6'd10, 32'd4, 32'd5, 5'd0, 5'd0, 32'h40C, 32'd0, 5'd29);
    tick(1);
    rollback_flag_from_rob = 1'b0;
    ena_from_dsp = 1'b0;
    rs_cdb(1'b0, 5'd0, 32'd0);
    occ = 0;
    check("rollback_ena", {31'd0, ena_to_alu}, 32'd0);
    check("rollback_full", {31'd0, full_to_if}, 32'd0);
    tick(4);
    c = cyc;
    expect_issue(6'd10, 32'h6, 32'h7, 32'h410, 32'd3, 5'd30, c + 2);
    dispatch(6'd10, 32'h6, 32'h7, 5'd0, 5'd0, 32'h410, 32'd3, 5'd30);
    tick(3);

    // Asynchronous reset while an issue is on the outputs
    c = cyc;
    expect_issue(6'd11, 32'h50, 32'h51, 32'h500, 32'd5, 5'd14, c + 2);
    dispatch(6'd11, 32'h50, 32'h51, 5'd0, 5'd0, 32'h500, 32'd5, 5'd14);
    dispatch(6'd11, 32'h0, 32'h52, 5'd27, 5'd0, 32'h504, 32'd6, 5'd15);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ena", {31'd0, ena_to_alu}, 32'd0);
    check("async_rst_v1", V1_to_alu, 32'd0);
    check("async_rst_v2", V2_to_alu, 32'd0);
    check("async_rst_pc", pc_to_alu, 32'd0);
    check("async_rst_rob", {27'd0, rob_id_to_alu}, 32'd0);
    check("async_rst_op", {26'd0, openum_to_alu}, 32'd0);
    tick(1);
    rst = 1'b1;
    occ = 0;
    rs_cdb(1'b1, 5'd27, 32'h88);
    tick(1);
    rs_cdb(1'b0, 5'd0, 32'd0);
    c = cyc;
    expect_issue(6'd12, 32'h60, 32'h61, 32'h600, 32'd7, 5'd17, c + 2);
    dispatch(6'd12, 32'h60, 32'h61, 5'd0, 5'd0, 32'h600, 32'd7, 5'd17);
    tick(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter RS_SIZE, default 16: number of entries; power of two, at least 2.
REQ-002 Parameter ROB_ID_W, default 5: ROB tag width; tag 0 means "no dependency".
REQ-003 Parameter OPENUM_W, default 6: internal opcode width; DATA/ADDR width fixed at 32.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rdy  in  1  global enable; low freezes all state and holds all outputs.
REQ-007 ena_from_dsp  in  1  dispatch-insert strobe.
REQ-008 openum_from_dsp  in  OPENUM_W  operation.
REQ-009 V1_from_dsp / V2_from_dsp  in  32 each  operand values.
REQ-010 Q1_from_dsp / Q2_from_dsp  in  ROB_ID_W each  operand tags.
REQ-011 pc_from_dsp, imm_from_dsp  in  32 each  pc and immediate.
REQ-012 rob_id_from_dsp  in  ROB_ID_W  destination tag.
REQ-013 valid_from_rs_cdb, rob_id_from_rs_cdb, result_from_rs_cdb  in  1/ROB_ID_W/32  ALU broadcast.
REQ-014 valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb  in  1/ROB_ID_W/32  load/store broadcast.
REQ-015 rollback_flag_from_rob  in  1  flush request.
REQ-016 full_to_if  out  1  stop-fetch indication.
REQ-017 ena_to_alu  out  1  issue strobe, one cycle per issued op.
REQ-018 openum_to_alu, V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu, rob_id_to_alu  out  matching widths  issued operation.

Function
REQ-019 Each entry SHALL hold: busy, openum, V1, V2, Q1, Q2, pc, imm, rob_id.
REQ-020 On ena_from_dsp, the SHALL write into the lowest-index non-busy entry and set its busy bit.
REQ-021 On insert, a tag matching a valid CDB tag in the same cycle SHALL be stored as 0, with the value from that CDB; the RS CDB takes priority over the LS CDB on a tag match.
REQ-022 Each cycle, every busy entry with a nonzero Qi matching a valid CDB tag SHALL clear Qi to 0 and load Vi from that CDB; both operands can wake in the same cycle.
REQ-023 An entry is ready when busy, Q1==0 and Q2==0; the lowest-index ready entry SHALL issue.
REQ-024 Issue SHALL register the entry's fields onto the *_to_alu outputs, pulse ena_to_alu for one cycle and clear busy; at most one issue per cycle.
REQ-025 Without a ready entry, ena_to_alu SHALL be 0; the data outputs hold their last value.
REQ-026 full_to_if SHALL be registered, high when the busy count after the current update is at least RS_SIZE-1; this leaves one slot of margin for an in-flight dispatch.
REQ-027 A slot freed by issue SHALL NOT be reused by an insert in the same cycle.
REQ-028 rollback_flag_from_rob SHALL clear all busy bits and force ena_to_alu=0 and full_to_if=0 next cycle; rollback overrides a same-cycle insert, wakeup and issue.
REQ-029 An insert while all entries are busy SHALL be dropped; this is a protocol violation and is flagged by a bench assertion.
REQ-030 With rdy=0, inserts, wakeups and issues SHALL NOT take effect.

Reset
REQ-031 While rst=0: all busy bits 0, ena_to_alu=0, full_to_if=0, and all *_to_alu data outputs 0, applied asynchronously.
REQ-032 Reset mid-operation SHALL discard all entries; the first insert after release SHALL land in entry 0.

Configuration
REQ-033 Macro RS_WAKEUP_ISSUE_EN defined: an entry made ready by a CDB broadcast SHALL be issuable in that same cycle, with the CDB value forwarded to the V output; insert-time wakeup (REQ-021) does not make an entry issuable before the next cycle.
REQ-034 Macro RS_WAKEUP_ISSUE_EN undefined: readiness SHALL be evaluated on registered Q only, so the earliest issue is one cycle after wakeup.

Verification
REQ-035 Insert add, Q1=Q2=0, V1=5, V2=7, rob_id=3 -> next cycle ena_to_alu=1, V1=5, V2=7, rob_id_to_alu=3.
REQ-036 Insert Q1=4; two cycles later RS CDB broadcasts tag 4, value 0x10 -> V1_to_alu=0x10, issue in the broadcast cycle with the macro and one cycle later without.
REQ-037 Insert Q2=6 in the same cycle that LS CDB broadcasts tag 6, value 0xAB -> entry stored ready, issues next cycle with V2=0xAB.
REQ-038 Insert 15 independent-free (dependent) entries with RS_SIZE=16 -> full_to_if=1 after the 15th; one issue or rollback -> full_to_if=0.
REQ-039 Three ready entries plus rollback in the same cycle -> ena_to_alu=0 next cycle, all busy bits 0, no later issue.
REQ-040 Assert rst=0 mid-burst -> outputs zero immediately; after release, insert + issue yields rob_id from entry 0.
